// File: rtl/elliptic_curve_structs.sv
// Shared curve types, field arithmetic and MSM controller state encoding.
// The field is small (p=17, y^2 = x^3 + 2x + 2) so the point units stay compact.
package elliptic_curve_structs;

    localparam int COORD_W = 8;
    localparam logic [COORD_W-1:0] FIELD_P = 8'd17;
    localparam logic [COORD_W-1:0] CURVE_A = 8'd2;

    typedef logic [COORD_W-1:0] felem_t;

    typedef struct packed {
        felem_t x;
        felem_t y;
    } curve_point_t;

    localparam curve_point_t POINT_ZERO = '0;

    typedef enum logic [3:0] {
        IDLE,
        MUL_START,
        MUL_WAIT,
        FOLD,
        ADD_START,
        ADD_WAIT,
        DBL_START,
        DBL_WAIT,
        CHECK_LAST,
        OUT
    } msm_state_t;

    function automatic felem_t f_add(felem_t a, felem_t b);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FIELD_P}) begin
            s = s - {1'b0, FIELD_P};
        end
        return s[COORD_W-1:0];
    endfunction

    // Operands are already reduced, so a wrap-around sum lands back in range.
    function automatic felem_t f_sub(felem_t a, felem_t b);
        return (a >= b) ? felem_t'(a - b) : felem_t'(a + FIELD_P - b);
    endfunction

    function automatic felem_t f_mul(felem_t a, felem_t b);
        logic [2*COORD_W-1:0] p;
        p = {{COORD_W{1'b0}}, a} * {{COORD_W{1'b0}}, b};
        p = p % {{COORD_W{1'b0}}, FIELD_P};
        return p[COORD_W-1:0];
    endfunction

    // Fermat inverse: a^(p-2), square-and-multiply from the top bit.
    function automatic felem_t f_inv(felem_t a);
        felem_t r;
        felem_t e;
        e = FIELD_P - felem_t'(2);
        r = felem_t'(1);
        for (int i = COORD_W - 1; i >= 0; i--) begin
            r = f_mul(r, r);
            if (e[i]) begin
                r = f_mul(r, a);
            end
        end
        return r;
    endfunction

    function automatic curve_point_t pt_add(curve_point_t p, curve_point_t q);
        felem_t lam;
        felem_t x3;
        curve_point_t r;
        lam = f_mul(f_sub(q.y, p.y), f_inv(f_sub(q.x, p.x)));
        x3 = f_sub(f_sub(f_mul(lam, lam), p.x), q.x);
        r.x = x3;
        r.y = f_sub(f_mul(lam, f_sub(p.x, x3)), p.y);
        return r;
    endfunction

    function automatic curve_point_t pt_double(curve_point_t p);
        felem_t lam;
        felem_t x3;
        curve_point_t r;
        lam = f_mul(f_add(f_mul(felem_t'(3), f_mul(p.x, p.x)), CURVE_A),
                    f_inv(f_add(p.y, p.y)));
        x3 = f_sub(f_mul(lam, lam), f_add(p.x, p.x));
        r.x = x3;
        r.y = f_sub(f_mul(lam, f_sub(p.x, x3)), p.y);
        return r;
    endfunction

endpackage

// File: rtl/point_add.sv
// Affine point addition for distinct x; Reset pulse starts, Done holds R.
module point_add
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);

    localparam int LAT = 3;

    logic [1:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    curve_point_t r_q, r_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        r_d    = r_q;
        if (!done_q) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                r_d    = pt_add(P, Q);
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q  <= 2'(LAT);
            done_q <= 1'b0;
            r_q    <= POINT_ZERO;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            r_q    <= r_d;
        end
    end

    assign R    = r_q;
    assign Done = done_q;

endmodule

// File: rtl/point_double.sv
// Affine point doubling (y != 0); Reset pulse starts, Done holds R.
module point_double
    import elliptic_curve_structs::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    output curve_point_t R,
    output logic         Done
);

    localparam int LAT = 2;

    logic [1:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    curve_point_t r_q, r_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        r_d    = r_q;
        if (!done_q) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                r_d    = pt_double(P);
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q  <= 2'(LAT);
            done_q <= 1'b0;
            r_q    <= POINT_ZERO;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            r_q    <= r_d;
        end
    end

    assign R    = r_q;
    assign Done = done_q;

endmodule

// File: rtl/point_mul.sv
// Scalar multiplication R = k*P, MSB-first double-and-add, one scalar bit per cycle.
// Infinity is tracked internally and reported as POINT_ZERO.
module point_mul
    import elliptic_curve_structs::*;
#(
    parameter int SCALAR_W = 256
) (
    input  logic                clk,
    input  logic                Reset,
    input  curve_point_t        P,
    input  logic [SCALAR_W-1:0] k,
    output curve_point_t        R,
    output logic                Done
);

    localparam int IDX_W = $clog2(SCALAR_W);

    logic [IDX_W-1:0] idx_q, idx_d;
    curve_point_t     acc_q, acc_d;
    logic             inf_q, inf_d;
    logic             done_q, done_d;
    curve_point_t     r_q, r_d;

    curve_point_t     dbl_pt;
    logic             dbl_inf;
    curve_point_t     sum_pt;
    logic             sum_inf;

    always_comb begin
        dbl_pt  = pt_double(acc_q);
        dbl_inf = inf_q || (acc_q.y == '0);
        sum_pt  = dbl_pt;
        sum_inf = dbl_inf;
        if (k[idx_q]) begin
            if (dbl_inf) begin
                sum_pt  = P;
                sum_inf = 1'b0;
            end else if (dbl_pt.x != P.x) begin
                sum_pt = pt_add(dbl_pt, P);
            end else if (dbl_pt.y == P.y) begin
                sum_pt = pt_double(P);
            end else begin
                sum_inf = 1'b1;
            end
        end
    end

    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        inf_d  = inf_q;
        done_d = done_q;
        r_d    = r_q;
        if (!done_q) begin
            acc_d = sum_pt;
            inf_d = sum_inf;
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
                done_d = 1'b1;
                r_d    = sum_inf ? POINT_ZERO : sum_pt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            idx_q  <= IDX_W'(SCALAR_W - 1);
            acc_q  <= POINT_ZERO;
            inf_q  <= 1'b1;
            done_q <= 1'b0;
            r_q    <= POINT_ZERO;
        end else begin
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            inf_q  <= inf_d;
            done_q <= done_d;
            r_q    <= r_d;
        end
    end

    assign R    = r_q;
    assign Done = done_q;

endmodule

// File: rtl/msm_accumulator.sv
// MSM front end: multiplies each (P_i, k_i) pair and folds the products into a
// running sum, presenting the batch total on a valid/ready output.
module msm_accumulator
    import elliptic_curve_structs::*;
#(
    parameter int SCALAR_W = 256,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  curve_point_t        in_point,
    input  logic [SCALAR_W-1:0] in_scalar,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output curve_point_t        out_point,
    output logic                out_infinity,
    output logic [COUNT_W-1:0]  out_count,
    output logic                busy
);

    msm_state_t          state_q, state_d;
    logic                in_ready_q, in_ready_d;
    curve_point_t        pt_q, pt_d;
    logic [SCALAR_W-1:0] scalar_q, scalar_d;
    logic                last_q, last_d;
    curve_point_t        prod_q, prod_d;
    curve_point_t        acc_q, acc_d;
    logic                acc_valid_q, acc_valid_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic                mul_reset, add_reset, dbl_reset;
    logic                mul_done, add_done, dbl_done;
    curve_point_t        mul_r, add_r, dbl_r;

    // Units are held in reset while the block is, then pulsed once per operation.
    assign mul_reset = !Reset_n || (state_q == MUL_START);
    assign add_reset = !Reset_n || (state_q == ADD_START);
    assign dbl_reset = !Reset_n || (state_q == DBL_START);

    point_mul #(
        .SCALAR_W(SCALAR_W)
    ) u_mul (
        .clk  (clk),
        .Reset(mul_reset),
        .P    (pt_q),
        .k    (scalar_q),
        .R    (mul_r),
        .Done (mul_done)
    );

    point_add u_add (
        .clk  (clk),
        .Reset(add_reset),
        .P    (acc_q),
        .Q    (prod_q),
        .R    (add_r),
        .Done (add_done)
    );

    point_double u_dbl (
        .clk  (clk),
        .Reset(dbl_reset),
        .P    (acc_q),
        .R    (dbl_r),
        .Done (dbl_done)
    );

    always_comb begin
        state_d     = state_q;
        pt_d        = pt_q;
        scalar_d    = scalar_q;
        last_d      = last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    pt_d     = in_point;
                    scalar_d = in_scalar;
                    last_d   = in_last;
                    // point_mul must never see k=0, so such pairs are skipped.
                    state_d  = (in_scalar == '0) ? CHECK_LAST : MUL_START;
                end
            end
            MUL_START: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_r;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                if (count_q != '1) begin
                    count_d = count_q + COUNT_W'(1);
                end
                if (!acc_valid_q) begin
                    acc_d       = prod_q;
                    acc_valid_d = 1'b1;
                    state_d     = CHECK_LAST;
                end else if (prod_q.x != acc_q.x) begin
                    state_d = ADD_START;
                end else if (prod_q.y == acc_q.y) begin
                    state_d = DBL_START;
                end else begin
                    // prod == -acc: the sum collapses to infinity.
                    acc_d       = POINT_ZERO;
                    acc_valid_d = 1'b0;
                    state_d     = CHECK_LAST;
                end
            end
            ADD_START: state_d = ADD_WAIT;
            ADD_WAIT: begin
                if (add_done) begin
                    acc_d   = add_r;
                    state_d = CHECK_LAST;
                end
            end
            DBL_START: state_d = DBL_WAIT;
            DBL_WAIT: begin
                if (dbl_done) begin
                    acc_d   = dbl_r;
                    state_d = CHECK_LAST;
                end
            end
            CHECK_LAST: state_d = last_q ? OUT : IDLE;
            OUT: begin
                if (out_ready) begin
                    acc_d       = POINT_ZERO;
                    acc_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            pt_q        <= POINT_ZERO;
            scalar_q    <= '0;
            last_q      <= 1'b0;
            prod_q      <= POINT_ZERO;
            acc_q       <= POINT_ZERO;
            acc_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pt_q        <= pt_d;
            scalar_q    <= scalar_d;
            last_q      <= last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            count_q     <= count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == OUT);
    assign out_point    = (out_valid && acc_valid_q) ? acc_q : POINT_ZERO;
    assign out_infinity = out_valid && !acc_valid_q;
    assign out_count    = out_valid ? count_q : '0;

endmodule

// File: tb/tb_msm_accumulator.sv
// Directed bench for msm_accumulator: every batch is reduced to a multiple of
// G=(5,1) on y^2=x^3+2x+2 over F_17 (group order 19) and checked against it.
module tb_msm_accumulator;
    import elliptic_curve_structs::*;

    localparam int SW    = 256;
    localparam int CW    = 16;
    localparam int PM    = 17;
    localparam int ORDER = 19;

    logic              clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    curve_point_t      in_point = POINT_ZERO;
    logic [SW-1:0]     in_scalar = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    curve_point_t      out_point;
    logic              out_infinity;
    logic [CW-1:0]     out_count;
    logic              busy;

    msm_accumulator #(.SCALAR_W(SW), .COUNT_W(CW)) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_point    (in_point),
        .in_scalar   (in_scalar),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_point   (out_point),
        .out_infinity(out_infinity),
        .out_count   (out_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_sum = 0;     // batch sum expressed as a multiple of G, mod ORDER
    int exp_cnt = 0;
    int results = 0;
    int mul_starts = 0;
    int add_starts = 0;
    int dbl_starts = 0;
    time last_acc_t = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int md(input int a);
        int r;
        r = a % PM;
        if (r < 0) r += PM;
        return r;
    endfunction

    function automatic int finv(input int a);
        for (int i = 1; i < PM; i++) begin
            if (md(a * i) == 1) return i;
        end
        return 0;
    endfunction

    function automatic void ec_add_m(input int x1, input int y1, input int i1,
                                     input int x2, input int y2, input int i2,
                                     output int x3, output int y3, output int i3);
        int lam;
        x3 = 0; y3 = 0; i3 = 0;
        if (i1 != 0) begin
            x3 = x2; y3 = y2; i3 = i2;
        end else if (i2 != 0) begin
            x3 = x1; y3 = y1; i3 = i1;
        end else if (x1 == x2 && md(y1 + y2) == 0) begin
            i3 = 1;
        end else begin
            if (x1 == x2) lam = md((3 * x1 * x1 + 2) * finv(md(2 * y1)));
            else          lam = md(md(y2 - y1) * finv(md(x2 - x1)));
            x3 = md(lam * lam - x1 - x2);
            y3 = md(lam * (x1 - x3) - y1);
        end
    endfunction

    // n*G by repeated addition.
    function automatic void mult_g(input int n, output int x, output int y, output int inf);
        int tx, ty, ti;
        x = 0; y = 0; inf = 1;
        for (int i = 0; i < n; i++) begin
            ec_add_m(x, y, inf, 5, 1, 0, tx, ty, ti);
            x = tx; y = ty; inf = ti;
        end
    endfunction

    always @(negedge clk) begin
        if (Reset_n) begin
            if (dut.mul_reset) mul_starts++;
            if (dut.add_reset) add_starts++;
            if (dut.dbl_reset) dbl_starts++;
        end
    end

    // Output checker: every cycle of out_valid against the model.
    always @(negedge clk) begin
        int ex, ey, einf;
        if (Reset_n && out_valid) begin
            mult_g(exp_sum, ex, ey, einf);
            chk("out_infinity", out_infinity, einf);
            chk("out_x", out_point.x, (einf != 0) ? 0 : ex);
            chk("out_y", out_point.y, (einf != 0) ? 0 : ey);
            chk("out_count", out_count, exp_cnt);
            chk("in_ready_in_out", in_ready, 0);
            chk("busy_in_out", busy, 1);
            if (out_ready) begin
                $display("result: point=(%0d,%0d) inf=%0d count=%0d expected_multiple=%0d",
                         out_point.x, out_point.y, out_infinity, out_count, exp_sum);
                exp_sum = 0;
                exp_cnt = 0;
                results++;
            end
        end else if (Reset_n) begin
            chk("outs_idle", {out_point, out_infinity, out_count}, 0);
        end
    end

    task automatic send(input int px, input int py, input int k, input bit last, input int m);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid  = 1'b1;
        in_point.x = felem_t'(px);
        in_point.y = felem_t'(py);
        in_scalar = SW'(k);
        in_last   = last;
        exp_sum = (exp_sum + k * m) % ORDER;
        if (k != 0) exp_cnt++;
        @(posedge clk);
        last_acc_t = $time;
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("send: P=(%0d,%0d) k=%0d last=%0d", px, py, k, last);
    endtask

    task automatic wait_result();
        int r0, n;
        r0 = results;
        n = 0;
        while (results == r0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (results == r0) chk("result_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_out_rest"}, {out_point, out_infinity, out_count}, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, inf, m0, a0, d0;
        time t1;

        // Pin the model to the known multiples table.
        mult_g(3, x, y, inf);
        chk("model_3G_x", x, 10); chk("model_3G_y", y, 6);
        mult_g(7, x, y, inf);
        chk("model_7G_x", x, 0);  chk("model_7G_y", y, 6);
        mult_g(18, x, y, inf);
        chk("model_18G_x", x, 5); chk("model_18G_y", y, 16);
        mult_g(19, x, y, inf);
        chk("model_19G_inf", inf, 1);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        Reset_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", in_ready, 1);

        // (G,3) alone
        m0 = mul_starts; a0 = add_starts; d0 = dbl_starts;
        send(5, 1, 3, 1'b1, 1);
        wait_result();
        chk("b1_mul_starts", mul_starts - m0, 1);
        chk("b1_add_starts", add_starts - a0, 0);
        chk("b1_dbl_starts", dbl_starts - d0, 0);

        // (G,2),(G,5) -> 7G via one add
        m0 = mul_starts; a0 = add_starts; d0 = dbl_starts;
        send(5, 1, 2, 1'b0, 1);
        send(5, 1, 5, 1'b1, 1);
        wait_result();
        chk("b2_mul_starts", mul_starts - m0, 2);
        chk("b2_add_starts", add_starts - a0, 1);
        chk("b2_dbl_starts", dbl_starts - d0, 0);

        // (G,1),(G,1) -> 2G via doubling
        a0 = add_starts; d0 = dbl_starts;
        send(5, 1, 1, 1'b0, 1);
        send(5, 1, 1, 1'b1, 1);
        wait_result();
        chk("b3_add_starts", add_starts - a0, 0);
        chk("b3_dbl_starts", dbl_starts - d0, 1);

        // (G,1),(-G,1) -> infinity, count 2
        send(5, 1, 1, 1'b0, 1);
        send(5, 16, 1, 1'b1, 18);
        wait_result();

        // zero scalars only
        m0 = mul_starts;
        send(5, 1, 0, 1'b0, 1);
        t1 = last_acc_t;
        send(5, 1, 0, 1'b1, 1);
        chk("zero_pair_spacing", last_acc_t - t1, 20);
        wait_result();
        chk("zero_mul_starts", mul_starts - m0, 0);

        // result held while out_ready is low
        out_ready = 1'b0;
        send(5, 1, 4, 1'b1, 1);
        for (int n = 0; n < 3000 && !out_valid; n++) @(negedge clk);
        chk("held_out_valid_seen", out_valid, 1);
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        wait_result();
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("release_out_count", out_count, 0);

        // reset during MUL_WAIT of (G,9)
        send(5, 1, 9, 1'b1, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        Reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_sum = 0;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        send(5, 1, 2, 1'b1, 1);
        wait_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
